// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   N_REQ         : number of requesters
//   SEL_W         : width of the binary mux select
//   state_t       : arbiter state (IDLE / GRANT)
//   onehot_to_idx : one-hot grant vector -> binary index
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {IDLE, GRANT} state_t;

   // OR-reduction form: only correct for one-hot (or zero) inputs,
   // which is all the arbiter ever feeds it.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (oh[i]) idx = idx | SEL_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick over four requesters.
//   req         : request vector
//   ptr         : last served requester; search starts at ptr+1
//   pick_onehot : one-hot winner (zero when no request)
//   pick_idx    : binary index of the winner
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] pick_onehot,
   output logic [SEL_W-1:0] pick_idx
);

   logic [SEL_W-1:0] base;
   logic [7:0]       dbl_req;
   logic [7:0]       dbl_pick;
   logic [3:0]       rot;
   logic [3:0]       rot_pick;

   assign base    = ptr + 2'd1;

   // Rotate so that requester ptr+1 lands at bit 0.
   assign dbl_req = {req, req};
   assign rot     = dbl_req[base +: 4];

   // Lowest set bit wins in the rotated frame.
   assign rot_pick = rot & (~rot + 4'd1);

   // Rotate back into requester numbering.
   assign dbl_pick    = {rot_pick, rot_pick};
   assign pick_onehot = dbl_pick[(3'd4 - {1'b0, base}) +: 4];
   assign pick_idx    = onehot_to_idx(pick_onehot);

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter/sequencer for a 4-input W-bit AND-OR mux. A grant
// is held for a whole packet (until a handshake with last=1), followed by
// one IDLE bubble cycle before the next arbitration.
// Optional feature macro ARB_TIMEOUT_EN: revokes a grant after TIMEOUT
// consecutive GRANT cycles without in_valid from the owner, pulsing timeout.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/last/data    : four requester streams (data i at [i*W +: W])
//   in_ready              : per-requester ready
//   out_valid/last/data   : muxed output stream, out_ready from downstream
//   grant, sel, busy      : one-hot grant, binary select, GRANT-state flag
//   timeout               : (ARB_TIMEOUT_EN only) 1-cycle revoke pulse
module rr_mux_arbiter_4
   import arb_pkg::*;
#(
   parameter int W       = 4,
   parameter int TIMEOUT = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   in_valid,
   input  logic [N_REQ-1:0]   in_last,
   input  logic [N_REQ*W-1:0] in_data,
   output logic [N_REQ-1:0]   in_ready,
   output logic               out_valid,
   output logic               out_last,
   output logic [W-1:0]       out_data,
   input  logic               out_ready,
   output logic [N_REQ-1:0]   grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic               timeout
`endif
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must be in 2..255");
   end

   state_t           state, state_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [N_REQ-1:0] pick_onehot;
   logic [SEL_W-1:0] pick_idx;
   logic             end_pkt;
   logic             release_grant;

   rr_pick_4 u_pick (
      .req         (in_valid),
      .ptr         (ptr),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx)
   );

   // Output path: grant is zero in IDLE, so everything below reads as
   // idle without needing a state qualifier.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < N_REQ; i++)
         out_data = out_data | (in_data[i*W +: W] & {W{grant[i]}});
   end

   assign out_valid = |(in_valid & grant);
   assign out_last  = |(in_last & grant);
   assign in_ready  = grant & {N_REQ{out_ready}};
   assign busy      = (state == GRANT);
   assign end_pkt   = out_valid & out_ready & out_last;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] idle_cnt;
   logic       to_hit;

   // The cycle that would make the idle count reach TIMEOUT releases.
   assign to_hit        = busy && !out_valid && (idle_cnt == TO_LAST);
   assign release_grant = end_pkt | to_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= to_hit;
         if (!busy || out_valid || to_hit) idle_cnt <= '0;
         else                              idle_cnt <= idle_cnt + 8'd1;
      end
   end
`else
   assign release_grant = end_pkt;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      sel_nxt   = sel;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (|in_valid) begin
               grant_nxt = pick_onehot;
               sel_nxt   = pick_idx;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (release_grant) begin
               grant_nxt = '0;
               ptr_nxt   = sel;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         ptr   <= 2'd3;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
         ptr   <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: a packet-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rr_mux_arbiter_4;

   localparam int W  = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    iv, il, in_ready, grant;
   logic [4*W-1:0] id;
   logic          out_valid, out_last, ordy, busy;
   logic [W-1:0]  out_data;
   logic [1:0]    sel;
`ifdef ARB_TIMEOUT_EN
   logic          to;
`endif

   int total = 0;
   int bad   = 0;
   bit en    = 0;
   bit cap   = 0;
   int q_sel[$];
   int q_dat[$];

   always #5 clk = ~clk;

   rr_mux_arbiter_4 #(.W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_last(il), .in_data(id), .in_ready(in_ready),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
      .out_ready(ordy), .grant(grant), .sel(sel), .busy(busy)
`ifdef ARB_TIMEOUT_EN
      , .timeout(to)
`endif
   );

   // Reference model: who owns the path (-1 = nobody), who was served last.
   typedef struct {
      int owner;
      int ptr;
      int sel;
      int cnt;
      bit to;
   } mdl_t;

   mdl_t m = '{owner: -1, ptr: 3, sel: 0, cnt: 0, to: 1'b0};

   function automatic mdl_t mnext(mdl_t c, bit r, logic [3:0] v, logic [3:0] l, bit rdy);
      mdl_t n;
      bit   done;
      n    = c;
      n.to = 1'b0;
      if (r) begin
         n.owner = -1; n.ptr = 3; n.sel = 0; n.cnt = 0;
         return n;
      end
      if (c.owner < 0) begin
         for (int k = 1; k <= 4; k++) begin
            int cand;
            cand = (c.ptr + k) % 4;
            if (v[cand]) begin
               n.owner = cand; n.sel = cand; n.cnt = 0;
               break;
            end
         end
      end else begin
         done = v[c.owner] && rdy && l[c.owner];
`ifdef ARB_TIMEOUT_EN
         if (!v[c.owner]) begin
            if (c.cnt + 1 >= TO) begin done = 1'b1; n.to = 1'b1; n.cnt = 0; end
            else n.cnt = c.cnt + 1;
         end else n.cnt = 0;
`endif
         if (done) begin n.ptr = c.owner; n.owner = -1; end
      end
      return n;
   endfunction

   always @(posedge clk) m <= mnext(m, rst, iv, il, ordy);

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (en) begin
         logic [3:0]   eg;
         logic         ev, el;
         logic [W-1:0] ed;
         eg = (m.owner < 0) ? 4'd0 : 4'(1 << m.owner);
         ev = (m.owner >= 0) && iv[m.owner];
         el = (m.owner >= 0) && il[m.owner];
         ed = (m.owner >= 0) ? id[m.owner*W +: W] : '0;
         chk("m_grant",     grant,     eg);
         chk("m_sel",       sel,       m.sel);
         chk("m_busy",      busy,      m.owner >= 0);
         chk("m_out_valid", out_valid, ev);
         chk("m_out_last",  out_last,  el);
         chk("m_out_data",  out_data,  ed);
         chk("m_in_ready",  in_ready,  eg & {4{ordy}});
`ifdef ARB_TIMEOUT_EN
         chk("m_timeout",   to,        m.to);
`endif
      end
      if (cap && out_valid && ordy) begin
         q_sel.push_back(int'(sel));
         q_dat.push_back(int'(out_data));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; iv = 4'hF; il = 4'hF; id = {4'hD, 4'hC, 4'hB, 4'hA}; ordy = 1'b1;

      // Reset held two cycles with everyone requesting.
      tick(); en = 1;
      peek(); chk("rst_grant", grant, 4'h0); chk("rst_oval", out_valid, 1'b0);
      chk("rst_irdy", in_ready, 4'h0); chk("rst_busy", busy, 1'b0);
      tick();
      rst = 1'b0; cap = 1;
      peek(); chk("rst2_grant", grant, 4'h0);

      // Fairness: first grant is requester 0 one cycle after release.
      tick();
      peek(); chk("first_sel", sel, 2'd0); chk("first_grant", grant, 4'b0001);
      repeat (9) tick();
      iv = 4'h0; cap = 0;
      chk("fair_cnt", q_sel.size(), 5);
      if (q_sel.size() == 5) begin
         chk("fair_s0", q_sel[0], 0); chk("fair_s1", q_sel[1], 1);
         chk("fair_s2", q_sel[2], 2); chk("fair_s3", q_sel[3], 3);
         chk("fair_s4", q_sel[4], 0);
         chk("fair_d0", q_dat[0], 'hA); chk("fair_d1", q_dat[1], 'hB);
         chk("fair_d2", q_dat[2], 'hC); chk("fair_d3", q_dat[3], 'hD);
      end
      tick();
      peek(); chk("fair_idle", busy, 1'b0);

      // Packet lock: requester 2 holds the path for 3 beats while 1 waits.
      iv = 4'b0100; il = 4'b0000; id[8 +: 4] = 4'h1;
      tick();
      iv = 4'b0110;
      peek(); chk("lock_sel", sel, 2'd2); chk("lock_rdy1", in_ready, 4'b0100);
      chk("lock_d1", out_data, 4'h1);
      tick();
      id[8 +: 4] = 4'h2;
      peek(); chk("lock_rdy2", in_ready, 4'b0100); chk("lock_d2", out_data, 4'h2);
      tick();
      id[8 +: 4] = 4'h3; il[2] = 1'b1;
      peek(); chk("lock_rdy3", in_ready, 4'b0100); chk("lock_last", out_last, 1'b1);
      tick();
      iv = 4'b0010; il = 4'b0000;
      peek(); chk("lock_bubble", in_ready, 4'b0000);
      tick();
      peek(); chk("lock_next_sel", sel, 2'd1); chk("lock_next_grant", grant, 4'b0010);

      // Backpressure on requester 1.
      id[4 +: 4] = 4'h5; ordy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         peek();
         chk("bp_data", out_data, 4'h5); chk("bp_irdy", in_ready, 4'b0000);
         chk("bp_grant", grant, 4'b0010);
         tick();
      end
      ordy = 1'b1; il[1] = 1'b1;
      peek(); chk("bp_release", in_ready, 4'b0010);
      tick();
      iv = 4'b0000; il = 4'b0000;

      // Reset in the middle of a requester-3 packet.
      iv = 4'b1000; id[12 +: 4] = 4'h7;
      tick();
      peek(); chk("rmid_sel", sel, 2'd3);
      tick();
      id[12 +: 4] = 4'h8; rst = 1'b1; iv = 4'b1001;
      tick();
      rst = 1'b0;
      peek(); chk("rmid_grant", grant, 4'b0000);
      tick();
      peek(); chk("rmid_next", grant, 4'b0001);
      il[0] = 1'b1;
      tick();
      iv = 4'b0000; il = 4'b0000;

`ifdef ARB_TIMEOUT_EN
      // Requester 1 sends one non-last beat, then goes silent.
      iv = 4'b0110; id[4 +: 4] = 4'h9;
      tick();
      peek(); chk("to_sel", sel, 2'd1);
      tick();
      iv = 4'b0100;
      begin
         int n;
         n = 0;
         for (int k = 1; k <= 10; k++) begin
            tick(); peek();
            if (to) begin n = k; break; end
         end
         chk("to_after", n, 4);
      end
      tick();
      peek(); chk("to_next_sel", sel, 2'd2);
      iv = 4'b0000;
`endif

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
